// File: rtl/serial_rx_frame.sv
// serial_rx_frame: async serial receiver, start + DATA_W bits LSB first + stop.
// Define RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd/even).
module serial_rx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST    = BW'(DATA_W - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK_WAIT
  } state_e;
`endif

  state_e state_q, state_d;
  logic sync1_q, rx_s;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
  logic perr;

`ifdef RX_PARITY_EN
  logic perr_q, perr_d;
  assign perr = perr_q;
`else
  assign perr = PARITY_ODD & 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= rx_in;
      rx_s    <= sync1_q;
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ov_q    <= ov_d;
`ifdef RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    pe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (valid_q && rx_ready) valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cyc_q == HALF_M1) begin
          cyc_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc_q == FULL_M1) begin
          cyc_d = '0;
          sh_d  = {rx_s, sh_q[DATA_W-1:1]};
          bit_d = bit_q + BW'(1);
`ifdef RX_PARITY_EN
          if (bit_q == LAST) state_d = PARITY;
`else
          if (bit_q == LAST) state_d = STOP;
`endif
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (cyc_q == FULL_M1) begin
          cyc_d   = '0;
          perr_d  = rx_s ^ (^sh_q) ^ PARITY_ODD;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cyc_q == FULL_M1) begin
          cyc_d   = '0;
          fe_d    = !rx_s;
          pe_d    = perr;
          state_d = rx_s ? IDLE : BRK_WAIT;
          // a busy holding register keeps the old word unless it drains now
          if (rx_s && !perr) begin
            if (valid_q && !rx_ready) begin
              ov_d = 1'b1;
            end else begin
              data_d  = sh_q;
              valid_d = 1'b1;
            end
          end
        end
      end
      BRK_WAIT: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ov_q;
  assign busy       = (state_q != IDLE);

endmodule
